// File: rtl/intrapred_scheduler.sv
// ============================================================================
//  Module      : intrapred_scheduler
//  Description : Issues macroblock numbers into the 5-stage intra-prediction
//                pipeline, tracks stage occupancy and hands results downstream.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module intrapred_scheduler #(
    parameter int PIPE_DEPTH     = 5,
    parameter int MB_NUMBER_BITS = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [MB_NUMBER_BITS-1:0] frame_mbs,
    input  logic                      out_ready,
    output logic                      pipe_enable,
    output logic [31:0]               mbnumber,
    output logic [PIPE_DEPTH-1:0]     stage_valid,
    output logic                      out_valid,
    output logic [31:0]               out_mbnumber,
    output logic                      busy,
    output logic                      done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int                      PAD    = 32 - MB_NUMBER_BITS;
    localparam logic [MB_NUMBER_BITS-1:0] MB_ZERO = '0;
    localparam logic [MB_NUMBER_BITS-1:0] MB_ONE  = {{(MB_NUMBER_BITS-1){1'b0}}, 1'b1};

    logic [1:0]                state;
    logic [1:0]                state_next;
    logic [MB_NUMBER_BITS-1:0] frame_mbs_q;
    logic [MB_NUMBER_BITS-1:0] issue_cnt;
    logic [MB_NUMBER_BITS-1:0] done_cnt;
    logic [MB_NUMBER_BITS-1:0] tag [PIPE_DEPTH];

    logic stall;
    logic issue_ok;
    logic handshake;
    logic frame_complete;

    assign out_valid      = stage_valid[PIPE_DEPTH-1];
    assign out_mbnumber   = {{PAD{1'b0}}, tag[PIPE_DEPTH-1]};
    assign mbnumber       = {{PAD{1'b0}}, issue_cnt};
    assign stall          = out_valid & ~out_ready;
    assign issue_ok       = issue_cnt < frame_mbs_q;
    assign handshake      = (state == ST_RUN) & ~abort & out_valid & out_ready;
    // Completion looks at the registered count, so it lands one cycle after the last handshake.
    assign frame_complete = (state == ST_RUN) & (done_cnt == frame_mbs_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (abort)               state_next = ST_FLUSH;
                else if (frame_complete) state_next = ST_IDLE;
            end
            ST_FLUSH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pipe_enable = 1'b0;
        busy        = 1'b0;
        case (state)
            ST_RUN: begin
                pipe_enable = ~stall & ~abort;
                busy        = 1'b1;
            end
            ST_FLUSH: busy = 1'b1;
            default: begin
                pipe_enable = 1'b0;
                busy        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_mbs_q <= MB_ZERO;
            issue_cnt   <= MB_ZERO;
            done_cnt    <= MB_ZERO;
            stage_valid <= '0;
            done        <= 1'b0;
            for (int k = 0; k < PIPE_DEPTH; k++) tag[k] <= MB_ZERO;
        end else begin
            done <= frame_complete & ~abort;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        frame_mbs_q <= frame_mbs;
                        issue_cnt   <= MB_ZERO;
                        done_cnt    <= MB_ZERO;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // FLUSH performs the clean-up on the next cycle.
                    end else if (frame_complete) begin
                        stage_valid <= '0;
                        for (int k = 0; k < PIPE_DEPTH; k++) tag[k] <= MB_ZERO;
                    end else begin
                        if (handshake) done_cnt <= done_cnt + MB_ONE;
                        if (pipe_enable) begin
                            for (int k = PIPE_DEPTH-1; k > 0; k--) begin
                                stage_valid[k] <= stage_valid[k-1];
                                tag[k]         <= tag[k-1];
                            end
                            stage_valid[0] <= issue_ok;
                            tag[0]         <= issue_ok ? issue_cnt : MB_ZERO;
                            if (issue_ok) issue_cnt <= issue_cnt + MB_ONE;
                        end
                    end
                end
                ST_FLUSH: begin
                    frame_mbs_q <= MB_ZERO;
                    issue_cnt   <= MB_ZERO;
                    done_cnt    <= MB_ZERO;
                    stage_valid <= '0;
                    for (int k = 0; k < PIPE_DEPTH; k++) tag[k] <= MB_ZERO;
                end
                default: begin
                    stage_valid <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_intrapred_scheduler.sv
// ============================================================================
//  Module      : tb_intrapred_scheduler
//  Description : Directed self-checking bench for intrapred_scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_intrapred_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [11:0] frame_mbs;
    logic        out_ready;
    logic        pipe_enable;
    logic [31:0] mbnumber;
    logic [4:0]  stage_valid;
    logic        out_valid;
    logic [31:0] out_mbnumber;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    intrapred_scheduler #(
        .PIPE_DEPTH     (5),
        .MB_NUMBER_BITS (12)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .frame_mbs    (frame_mbs),
        .out_ready    (out_ready),
        .pipe_enable  (pipe_enable),
        .mbnumber     (mbnumber),
        .stage_valid  (stage_valid),
        .out_valid    (out_valid),
        .out_mbnumber (out_mbnumber),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int n);
        frame_mbs = 12'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   {31'b0, busy},        32'd0);
        check({tag, "_pe"},     {31'b0, pipe_enable}, 32'd0);
        check({tag, "_ov"},     {31'b0, out_valid},   32'd0);
        check({tag, "_done"},   {31'b0, done},        32'd0);
        check({tag, "_sv"},     {27'b0, stage_valid}, 32'd0);
        check({tag, "_mbn"},    mbnumber,             32'd0);
        check({tag, "_outmb"},  out_mbnumber,         32'd0);
    endtask

    // Collects results until done, checking order and hold-while-stalled.
    task automatic drain(input int n, input bit rnd, input int budget, output int cycles);
        int          next_exp = 0;
        bit          held     = 1'b0;
        bit          saw_done = 1'b0;
        logic [31:0] held_mb  = '0;
        cycles = 0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (held) begin
                check("stall_hold_valid", {31'b0, out_valid}, 32'd1);
                check("stall_hold_mb",    out_mbnumber,       held_mb);
            end
            if (out_valid) begin
                if (out_ready) begin
                    check("order_mb", out_mbnumber, 32'(next_exp));
                    next_exp++;
                    held = 1'b0;
                end else begin
                    held    = 1'b1;
                    held_mb = out_mbnumber;
                    check("stall_pe", {31'b0, pipe_enable}, 32'd0);
                end
            end else begin
                held = 1'b0;
            end
            tick();
            cycles++;
        end
        check("drain_done_seen", {31'b0, saw_done}, 32'd1);
        check("drain_count",     32'(next_exp),     32'(n));
        check("drain_busy_end",  {31'b0, busy},     32'd0);
        out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick();
            check("single_done", {31'b0, done}, 32'd0);
        end
    endtask

    logic [4:0] sv_tab [1:10];
    int         cyc;

    initial begin
        sv_tab[1] = 5'h01; sv_tab[2] = 5'h03; sv_tab[3] = 5'h07; sv_tab[4] = 5'h0E;
        sv_tab[5] = 5'h1C; sv_tab[6] = 5'h18; sv_tab[7] = 5'h10; sv_tab[8] = 5'h00;
        sv_tab[9] = 5'h00; sv_tab[10] = 5'h00;

        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        frame_mbs = '0;
        out_ready = 1'b1;
        #1;
        check_reset_outputs("por");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Frame of 3 with the consumer always ready.
        start_frame(3);
        check("t1_busy0", {31'b0, busy},        32'd1);
        check("t1_pe0",   {31'b0, pipe_enable}, 32'd1);
        check("t1_mbn0",  mbnumber,             32'd0);
        check("t1_sv0",   {27'b0, stage_valid}, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t1_sv",   {27'b0, stage_valid}, {27'b0, sv_tab[k]});
            check("t1_ov",   {31'b0, out_valid},   (k >= 5 && k <= 7) ? 32'd1 : 32'd0);
            if (k >= 5 && k <= 7) check("t1_outmb", out_mbnumber, 32'(k - 5));
            check("t1_done", {31'b0, done},        (k == 9) ? 32'd1 : 32'd0);
            check("t1_busy", {31'b0, busy},        (k <= 8) ? 32'd1 : 32'd0);
            if (k <= 4) check("t1_mbn", mbnumber, (k < 3) ? 32'(k) : 32'd3);
        end

        // Frame of 8 with a four-cycle stall on the first result.
        out_ready = 1'b0;
        start_frame(8);
        for (int k = 1; k <= 5; k++) tick();
        for (int s = 0; s < 4; s++) begin
            if (s > 0) tick();
            check("t2_ov",    {31'b0, out_valid},   32'd1);
            check("t2_outmb", out_mbnumber,         32'd0);
            check("t2_sv",    {27'b0, stage_valid}, 32'h1F);
            check("t2_mbn",   mbnumber,             32'd5);
            check("t2_pe",    {31'b0, pipe_enable}, 32'd0);
        end
        drain(8, 1'b0, 100, cyc);
        check("t2_cycles", 32'(cyc), 32'd9);

        // Empty frame.
        start_frame(0);
        check("t3_busy", {31'b0, busy},        32'd1);
        check("t3_pe",   {31'b0, pipe_enable}, 32'd1);
        check("t3_sv",   {27'b0, stage_valid}, 32'd0);
        tick();
        check("t3_done",  {31'b0, done},        32'd1);
        check("t3_busy1", {31'b0, busy},        32'd0);
        check("t3_sv1",   {27'b0, stage_valid}, 32'd0);
        tick();
        check("t3_done2", {31'b0, done}, 32'd0);

        // Abort in the third RUN cycle.
        start_frame(6);
        tick();
        tick();
        abort = 1'b1;
        #1;
        check("t4_pe_abort", {31'b0, pipe_enable}, 32'd0);
        tick();
        abort = 1'b0;
        check("t4_flush_busy", {31'b0, busy},        32'd1);
        check("t4_flush_sv",   {27'b0, stage_valid}, 32'h03);
        check("t4_flush_pe",   {31'b0, pipe_enable}, 32'd0);
        tick();
        check("t4_idle_busy", {31'b0, busy},        32'd0);
        check("t4_idle_sv",   {27'b0, stage_valid}, 32'd0);
        check("t4_idle_done", {31'b0, done},        32'd0);
        check("t4_idle_mbn",  mbnumber,             32'd0);
        tick();
        check("t4_idle_done2", {31'b0, done}, 32'd0);
        start_frame(2);
        check("t4_mbn0", mbnumber, 32'd0);
        tick();
        check("t4_mbn1", mbnumber, 32'd1);
        drain(2, 1'b0, 50, cyc);

        // Asynchronous reset mid-frame.
        start_frame(10);
        for (int k = 1; k <= 4; k++) tick();
        check("t5_mbn_pre", mbnumber, 32'd4);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        tick();
        reset = 1'b1;
        tick();
        start_frame(3);
        check("t5_mbn0", mbnumber, 32'd0);
        drain(3, 1'b0, 50, cyc);

        // Random backpressure over a 50-macroblock frame.
        start_frame(50);
        drain(50, 1'b1, 1000, cyc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
